// File: rtl/fir_decim_out.sv
// Output stage after the 16-tap moving-average FIR: drops warm-up samples, rounds away
// the x2^SHIFT coefficient gain, decimates by DECIM and buffers kept samples in a FWFT FIFO.
module fir_decim_out #(
    parameter int N      = 16,
    parameter int SHIFT  = 7,
    parameter int DECIM  = 4,
    parameter int WARMUP = 16,
    parameter int AW     = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  data_in,
    output logic [N-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   fifo_level,
    output logic          overflow
);

    localparam int WW    = $clog2(WARMUP + 2);
    localparam int PW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [WW-1:0] WMAX = WW'(WARMUP);
    localparam logic [PW-1:0] PMAX = PW'(DECIM - 1);

    logic [WW-1:0] wcnt;
    logic [PW-1:0] phase;
    logic          considered;
    logic          keep;
    logic [N:0]    rounded;
    logic [N-1:0]  scaled;
    logic [N-1:0]  stage_data;
    logic          stage_valid;

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push;
    logic          pop;
    logic          accept;

    // Extra MSB keeps the rounding add from wrapping near full scale.
    assign considered = (wcnt == WMAX);
    assign keep       = considered && (phase == '0);
    assign rounded    = {1'b0, data_in} + (N+1)'(1 << (SHIFT - 1));
    assign scaled     = N'(rounded >> SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt        <= '0;
            phase       <= '0;
            stage_valid <= 1'b0;
        end else begin
            if (!considered)
                wcnt <= wcnt + 1'b1;
            if (considered)
                phase <= (phase == PMAX) ? '0 : phase + 1'b1;
            stage_valid <= keep;
            if (keep)
                stage_data <= scaled;
        end
    end

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign out_valid = (fifo_level != '0);
    assign pop       = out_valid && out_ready;
    assign push      = stage_valid;
    assign accept    = push && ((fifo_level != FULL) || pop);
    assign out_data  = out_valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({accept, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (push && !accept)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wptr] <= stage_data;
    end

endmodule
